// File: rtl/a0_uart_pkg.sv
// Shared types and framing constants for the a0 UART trace transmitter.
package a0_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int   BYTES_PER_WORD = 4;
    localparam int   BITS_PER_BYTE  = 8;
    localparam logic UART_START     = 1'b0;
    localparam logic UART_STOP      = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and synchronous reset.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign level = r_count;

endmodule

// File: rtl/a0_uart_tx.sv
// Captures every new value of the CPU a0 register and streams it out as four
// UART 8N1 bytes, least-significant byte first, through a small word FIFO.
module a0_uart_tx
    import a0_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           a0_i,
    input  logic                            en_i,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic                            overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]     level_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic [LW-1:0]         w_level;

    uart_state_e           r_state, w_state_nxt;
    logic [CW-1:0]         r_baud, w_baud_nxt;
    logic [2:0]            r_bit_idx, w_bit_idx_nxt;
    logic [1:0]            r_byte_idx, w_byte_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  w_bit_done;
    logic [7:0]            w_cur_byte;
    logic [2:0]            w_bit_idx_inc;

    // A new value is any change seen while capture is enabled.
    assign w_push = en_i && (a0_i != r_prev);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // always_ff block sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (en_i) r_prev <= a0_i;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (a0_i),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign w_bit_done    = (r_baud == CW'(CLKS_PER_BIT - 1));
    assign w_cur_byte    = r_shift[7:0];
    assign w_bit_idx_inc = r_bit_idx + 3'd1;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = UART_STOP;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_nxt    = w_fifo_dout;
                    w_byte_idx_nxt = '0;
                    w_tx_nxt       = UART_START;
                    w_state_nxt    = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = w_cur_byte[0];
                    w_state_nxt   = DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'(BITS_PER_BYTE - 1)) begin
                        w_tx_nxt    = UART_STOP;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = w_bit_idx_inc;
                        w_tx_nxt      = w_cur_byte[w_bit_idx_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_baud_nxt = '0;
                    // Next byte follows the stop bit with no idle gap.
                    if (r_byte_idx != 2'(BYTES_PER_WORD - 1)) begin
                        w_byte_idx_nxt = r_byte_idx + 1'b1;
                        w_shift_nxt    = r_shift >> BITS_PER_BYTE;
                        w_tx_nxt       = UART_START;
                        w_state_nxt    = START;
                    end else begin
                        w_tx_nxt    = UART_STOP;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_tx_nxt    = UART_STOP;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= UART_STOP;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign tx_o       = r_tx;
    assign busy_o     = !w_empty || (r_state != IDLE);
    assign overflow_o = r_overflow;
    assign level_o    = w_level;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Self-checking bench for a0_uart_tx: per-cycle vector table plus directed
// sequences, with a UART receiver model decoding the serial line.
module tb_a0_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int WORD_CYCLES = 40 * CPB;

    logic        clk;
    logic        rst;
    logic [31:0] a0_i;
    logic        en_i;
    logic        tx_o;
    logic        busy_o;
    logic        overflow_o;
    logic [3:0]  level_o;

    a0_uart_tx #(
        .DATA_WIDTH   (32),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a0_i       (a0_i),
        .en_i       (en_i),
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o),
        .level_o    (level_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rst_cnt  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_cnt <= rst_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART receiver model: samples mid-bit on falling clock edges.
    logic [31:0] rx_words[$];
    int          rx_starts[$];
    logic [7:0]  rx_bytes[$];
    int          rx_falls = 0;
    logic        mon_busy = 1'b0;
    logic [7:0]  mon_byte;
    logic [31:0] mon_word;
    int          mon_nbytes = 0;
    int          mon_snap;
    int          mon_t;
    int          mon_word_t;

    always begin : rx_mon
        @(negedge clk);
        if (tx_o === 1'b0) begin
            mon_busy = 1'b1;
            mon_snap = rst_cnt;
            mon_t    = cyc;
            rx_falls++;
            for (int k = 1; k < 10 * CPB; k++) begin
                @(negedge clk);
                if (k == CPB / 2 && rst_cnt == mon_snap)
                    check("rx_start_bit", {31'd0, tx_o}, 32'd0);
                if (k >= CPB + CPB / 2 && k < 9 * CPB && (k % CPB) == CPB / 2)
                    mon_byte = {tx_o, mon_byte[7:1]};
                if (k == 9 * CPB + CPB / 2 && rst_cnt == mon_snap)
                    check("rx_stop_bit", {31'd0, tx_o}, 32'd1);
            end
            if (rst_cnt != mon_snap) begin
                mon_nbytes = 0;
            end else begin
                rx_bytes.push_back(mon_byte);
                if (mon_nbytes == 0) mon_word_t = mon_t;
                mon_word = {mon_byte, mon_word[31:8]};
                mon_nbytes++;
                if (mon_nbytes == 4) begin
                    rx_words.push_back(mon_word);
                    rx_starts.push_back(mon_word_t);
                    mon_nbytes = 0;
                end
            end
            mon_busy = 1'b0;
        end
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] a0;
        logic [3:0]  level;
        logic        busy;
        logic        ovf;
        logic        tx;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic [31:0] a,
                                input logic [3:0] l, input logic b, input logic o, input logic t);
        vec_t v;
        v.rst = r; v.en = e; v.a0 = a; v.level = l; v.busy = b; v.ovf = o; v.tx = t;
        return v;
    endfunction

    vec_t vecs [13];
    int   lvl_peak;

    task automatic clear_rx();
        rx_words.delete();
        rx_starts.delete();
        rx_bytes.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((busy_o || mon_busy) && n < budget) begin
            @(negedge clk);
            if (int'(level_o) > lvl_peak) lvl_peak = int'(level_o);
            n++;
        end
        check({name, "_drain_idle"}, {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        rst  = 1'b1;
        en_i = 1'b0;
        a0_i = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_rst_tx"},    {31'd0, tx_o},       32'd1);
        check({name, "_rst_busy"},  {31'd0, busy_o},     32'd0);
        check({name, "_rst_ovf"},   {31'd0, overflow_o}, 32'd0);
        check({name, "_rst_level"}, {28'd0, level_o},    32'd0);
    endtask

    task automatic check_start_gaps(input string name);
        for (int i = 1; i < rx_starts.size(); i++)
            check($sformatf("%s_gap%0d", name, i), rx_starts[i] - rx_starts[i-1], WORD_CYCLES + 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int f0;
        rst  = 1'b1;
        en_i = 1'b0;
        a0_i = 32'd0;
        @(negedge clk);

        // Per-cycle table: reset, then values 1..10 one per cycle (10 overflows).
        vecs[0]  = mk(1, 0, 32'd0,  4'd0, 0, 0, 1);
        vecs[1]  = mk(0, 1, 32'd0,  4'd0, 0, 0, 1);
        vecs[2]  = mk(0, 1, 32'd1,  4'd1, 1, 0, 1);
        vecs[3]  = mk(0, 1, 32'd2,  4'd1, 1, 0, 0);
        vecs[4]  = mk(0, 1, 32'd3,  4'd2, 1, 0, 0);
        vecs[5]  = mk(0, 1, 32'd4,  4'd3, 1, 0, 0);
        vecs[6]  = mk(0, 1, 32'd5,  4'd4, 1, 0, 0);
        vecs[7]  = mk(0, 1, 32'd6,  4'd5, 1, 0, 1);
        vecs[8]  = mk(0, 1, 32'd7,  4'd6, 1, 0, 1);
        vecs[9]  = mk(0, 1, 32'd8,  4'd7, 1, 0, 1);
        vecs[10] = mk(0, 1, 32'd9,  4'd8, 1, 0, 1);
        vecs[11] = mk(0, 1, 32'd10, 4'd8, 1, 1, 0);
        vecs[12] = mk(0, 0, 32'h55, 4'd8, 1, 1, 0);

        for (int k = 0; k < 13; k++) begin
            rst  = vecs[k].rst;
            en_i = vecs[k].en;
            a0_i = vecs[k].a0;
            @(negedge clk);
            check($sformatf("vec%0d_level", k), {28'd0, level_o},    {28'd0, vecs[k].level});
            check($sformatf("vec%0d_busy", k),  {31'd0, busy_o},     {31'd0, vecs[k].busy});
            check($sformatf("vec%0d_ovf", k),   {31'd0, overflow_o}, {31'd0, vecs[k].ovf});
            check($sformatf("vec%0d_tx", k),    {31'd0, tx_o},       {31'd0, vecs[k].tx});
        end
        drain("ovf", 3000);
        check("ovf_word_count", rx_words.size(), 9);
        for (int i = 0; i < rx_words.size() && i < 9; i++)
            check($sformatf("ovf_word%0d", i), rx_words[i], i + 1);
        check_start_gaps("ovf");
        check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
        do_reset("ovf");

        // Single word: latency, byte order, frame length.
        clear_rx();
        en_i = 1'b1;
        a0_i = 32'h1234_5678;
        @(negedge clk);
        check("lat_e1_tx",    {31'd0, tx_o},    32'd1);
        check("lat_e1_level", {28'd0, level_o}, 32'd1);
        @(negedge clk);
        check("lat_e2_tx",    {31'd0, tx_o},    32'd0);
        check("lat_e2_level", {28'd0, level_o}, 32'd0);
        check("lat_e2_busy",  {31'd0, busy_o},  32'd1);
        n = 0;
        while (busy_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("single_frame_len", n, WORD_CYCLES);
        repeat (3) @(negedge clk);
        check("single_word_count", rx_words.size(), 1);
        if (rx_words.size() > 0) check("single_word", rx_words[0], 32'h1234_5678);
        check("single_byte_count", rx_bytes.size(), 4);
        for (int i = 0; i < rx_bytes.size() && i < 4; i++)
            check($sformatf("single_byte%0d", i), rx_bytes[i], (32'h1234_5678 >> (8 * i)) & 32'hFF);

        // Held value sent once; change with capture disabled is ignored.
        clear_rx();
        a0_i = 32'h5;
        repeat (50) @(negedge clk);
        drain("dup", 400);
        check("dup_word_count", rx_words.size(), 1);
        if (rx_words.size() > 0) check("dup_word", rx_words[0], 32'h5);
        f0   = rx_falls;
        en_i = 1'b0;
        a0_i = 32'h6;
        lvl_peak = 0;
        repeat (30) begin
            @(negedge clk);
            if (int'(level_o) > lvl_peak) lvl_peak = int'(level_o);
        end
        check("dis_level_peak", lvl_peak, 0);
        check("dis_no_start", rx_falls - f0, 0);
        check("dis_busy", {31'd0, busy_o}, 32'd0);

        // Back-to-back words 1, 2, 3.
        clear_rx();
        lvl_peak = 0;
        en_i = 1'b1;
        a0_i = 32'd1;
        for (int v = 2; v <= 3; v++) begin
            @(negedge clk);
            if (int'(level_o) > lvl_peak) lvl_peak = int'(level_o);
            a0_i = 32'(v);
        end
        @(negedge clk);
        if (int'(level_o) > lvl_peak) lvl_peak = int'(level_o);
        drain("b2b", 1000);
        check("b2b_level_peak", lvl_peak, 2);
        check("b2b_word_count", rx_words.size(), 3);
        for (int i = 0; i < rx_words.size() && i < 3; i++)
            check($sformatf("b2b_word%0d", i), rx_words[i], i + 1);
        check_start_gaps("b2b");

        // Reset in the data bits of byte 1 with three words queued.
        do_reset("mid");
        clear_rx();
        en_i = 1'b1;
        a0_i = 32'hA1;
        @(negedge clk);
        a0_i = 32'hA2;
        @(negedge clk);
        a0_i = 32'hA3;
        @(negedge clk);
        a0_i = 32'hA4;
        @(negedge clk);
        check("mid_queued", {28'd0, level_o}, 32'd3);
        repeat (47) @(negedge clk);
        rst  = 1'b1;
        a0_i = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_tx",    {31'd0, tx_o},       32'd1);
        check("mid_level", {28'd0, level_o},    32'd0);
        check("mid_busy",  {31'd0, busy_o},     32'd0);
        check("mid_ovf",   {31'd0, overflow_o}, 32'd0);
        f0 = rx_falls;
        repeat (100) @(negedge clk);
        check("mid_no_start", rx_falls - f0, 0);
        check("mid_no_word", rx_words.size(), 0);
        a0_i = 32'hCAFE_F00D;
        @(negedge clk);
        drain("mid", 400);
        check("mid_new_word_count", rx_words.size(), 1);
        if (rx_words.size() > 0) check("mid_new_word", rx_words[0], 32'hCAFE_F00D);

        // Full FIFO with a new value arriving on the IDLE pop edge.
        do_reset("full");
        clear_rx();
        en_i = 1'b1;
        a0_i = 32'd1;
        for (int v = 2; v <= 9; v++) begin
            @(negedge clk);
            a0_i = 32'(v);
        end
        @(negedge clk);
        check("full_level", {28'd0, level_o}, 32'd8);
        repeat (WORD_CYCLES - 8) @(negedge clk);
        check("full_hold_level", {28'd0, level_o}, 32'd8);
        check("full_hold_busy",  {31'd0, busy_o},  32'd1);
        @(negedge clk);
        check("full_idle_tx",    {31'd0, tx_o},    32'd1);
        check("full_idle_level", {28'd0, level_o}, 32'd8);
        a0_i = 32'hAB;
        @(negedge clk);
        check("full_pp_level", {28'd0, level_o},    32'd8);
        check("full_pp_ovf",   {31'd0, overflow_o}, 32'd0);
        check("full_pp_tx",    {31'd0, tx_o},       32'd0);
        drain("full", 3000);
        check("full_word_count", rx_words.size(), 10);
        for (int i = 0; i < rx_words.size() && i < 10; i++)
            check($sformatf("full_word%0d", i), rx_words[i], (i < 9) ? i + 1 : 32'hAB);
        check("full_end_ovf", {31'd0, overflow_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
